iqe_read_sched: RTL and testbench

IQE_READ_SCHED -- requirements
Module: iqe_read_sched

---
 rtl/iqe_read_sched_if.sv | 27 ++
 rtl/iqe_read_sched.sv | 131 +++++++++++++
 tb/tb_iqe_read_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/iqe_read_sched_if.sv
// Read-scheduler bus for the issue-queue engine: write/flush notifications in,
// read decision and mirrored occupancy out.
interface iqe_read_sched_if;
  logic       except;
  logic       except_thread;
  logic       wr_acc;
  logic       wr_thread;
  logic [4:0] wr_cnt;
  logic [1:0] thr_en;
  logic [1:0] be_slots;
  logic       stall;
  logic       read_thread;
  logic [2:0] read_cnt;
  logic [4:0] occ0;
  logic [4:0] occ1;
  logic       err;

  modport master (
    output except, except_thread, wr_acc, wr_thread, wr_cnt, thr_en, be_slots,
    input  stall, read_thread, read_cnt, occ0, occ1, err
  );

  modport slave (
    input  except, except_thread, wr_acc, wr_thread, wr_cnt, thr_en, be_slots,
    output stall, read_thread, read_cnt, occ0, occ1, err
  );
endinterface

// File: rtl/iqe_read_sched.sv
// Two-thread issue-queue read scheduler with mirrored occupancy tracking.
// Define IQE_SCHED_STARVE_EN to add per-thread starvation counters that force a grant.
module iqe_read_sched (
  input logic            clk,
  input logic            rst,
  iqe_read_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t             state;
  logic               last_hold;
  logic               last;
  logic [4:0]         occ [2];
  logic               err_q;

  logic [1:0]         elig;
  logic [1:0]         be;
  logic               sel;
  logic               grant;
  logic [1:0]         cnt;
  logic [4:0]         sel_occ;
  logic [5:0]         wr_val;
  logic signed [5:0]  sum [2];
  logic [4:0]         occ_next [2];
  logic [1:0]         bound_hit;

  // The state register already names the thread granted last cycle; last_hold
  // only carries it across IDLE cycles.
  assign last = (state == GRANT1) ? 1'b1 :
                (state == GRANT0) ? 1'b0 : last_hold;

`ifdef IQE_SCHED_STARVE_EN
  logic [2:0] starve [2];
  logic [1:0] starved;

  always_comb begin
    for (int t = 0; t < 2; t++) starved[t] = (starve[t] >= 3'd4);
  end
`endif

  always_comb begin
    be = (bus.be_slots == 2'd3) ? 2'd2 : bus.be_slots;
    for (int t = 0; t < 2; t++)
      elig[t] = bus.thr_en[t] && (occ[t] != 5'd0) &&
                !(bus.except && (bus.except_thread == t[0]));
    case (elig)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11: begin
        if (occ[0] > occ[1])      sel = 1'b0;
        else if (occ[1] > occ[0]) sel = 1'b1;
        else                      sel = ~last;
      end
      default: sel = last;
    endcase
`ifdef IQE_SCHED_STARVE_EN
    if ((elig == 2'b11) && (starved[0] != starved[1])) sel = starved[1];
`endif
    grant   = (elig != 2'b00) && (be != 2'd0);
    sel_occ = occ[sel];
    // be never exceeds 2, so min(occ, be) also honours the 2-entry read cap.
    cnt     = (sel_occ < {3'd0, be}) ? sel_occ[1:0] : be;
  end

  assign bus.stall       = ~grant;
  assign bus.read_thread = grant ? sel : last;
  assign bus.read_cnt    = grant ? (3'b001 << cnt) : 3'b001;
  assign bus.occ0        = occ[0];
  assign bus.occ1        = occ[1];
  assign bus.err         = err_q;

  always_comb begin
    case (bus.wr_cnt)
      5'b00010: wr_val = 6'd1;
      5'b00100: wr_val = 6'd2;
      5'b01000: wr_val = 6'd3;
      5'b10000: wr_val = 6'd4;
      default:  wr_val = 6'd0;
    endcase
  end

  // A flush zeroes its thread outright, so it never counts as a bound violation.
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      sum[t] = $signed({1'b0, occ[t]})
             + $signed((bus.wr_acc && (bus.wr_thread == t[0])) ? wr_val : 6'd0)
             - $signed((grant && (sel == t[0])) ? {4'd0, cnt} : 6'd0);
      bound_hit[t] = 1'b0;
      occ_next[t]  = sum[t][4:0];
      if (bus.except && (bus.except_thread == t[0])) begin
        occ_next[t] = 5'd0;
      end else if (sum[t] > 6'sd16) begin
        occ_next[t]  = 5'd16;
        bound_hit[t] = 1'b1;
      end else if (sum[t] < 6'sd0) begin
        occ_next[t]  = 5'd0;
        bound_hit[t] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ[0]    <= 5'd0;
      occ[1]    <= 5'd0;
      state     <= IDLE;
      last_hold <= 1'b0;
      err_q     <= 1'b0;
`ifdef IQE_SCHED_STARVE_EN
      starve[0] <= 3'd0;
      starve[1] <= 3'd0;
`endif
    end else begin
      occ[0]    <= occ_next[0];
      occ[1]    <= occ_next[1];
      err_q     <= err_q | (|bound_hit);
      last_hold <= last;
      state     <= grant ? (sel ? GRANT1 : GRANT0) : IDLE;
`ifdef IQE_SCHED_STARVE_EN
      for (int t = 0; t < 2; t++) begin
        if (!elig[t] || (grant && (sel == t[0])))
          starve[t] <= 3'd0;
        else if (starve[t] != 3'd7)
          starve[t] <= starve[t] + 3'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_iqe_read_sched.sv
// Self-checking bench for iqe_read_sched: directed scenarios plus randomized
// traffic compared against a queue-level occupancy/arbitration model.
module tb_iqe_read_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iqe_read_sched_if bus();

  iqe_read_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef IQE_SCHED_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  int m_occ [2];
  int m_last;
  int m_err;
  int m_starve [2];
  bit m_el [2];
  int e_grant, e_thread, e_n;

  int cur_rst, cur_ex, cur_ext, cur_wa, cur_wt, cur_wk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Arbitration decision from the rules: who may read, who wins, how many.
  task automatic modelDecide();
    int be;
    be = (int'(bus.be_slots) > 2) ? 2 : int'(bus.be_slots);
    for (int t = 0; t < 2; t++)
      m_el[t] = bus.thr_en[t] && (m_occ[t] > 0) && !(cur_ex == 1 && cur_ext == t);
    e_grant = ((m_el[0] || m_el[1]) && be > 0) ? 1 : 0;
    if (m_el[0] && m_el[1]) begin
      if (STARVE && ((m_starve[0] >= 4) != (m_starve[1] >= 4)))
        e_thread = (m_starve[1] >= 4) ? 1 : 0;
      else if (m_occ[0] != m_occ[1])
        e_thread = (m_occ[1] > m_occ[0]) ? 1 : 0;
      else
        e_thread = 1 - m_last;
    end else begin
      e_thread = m_el[1] ? 1 : 0;
    end
    if (e_grant == 0) e_thread = m_last;
    e_n = 0;
    if (e_grant == 1) e_n = (m_occ[e_thread] < be) ? m_occ[e_thread] : be;
  endtask

  task automatic modelUpdate();
    int v;
    if (cur_rst == 1) begin
      m_occ[0] = 0; m_occ[1] = 0; m_last = 0; m_err = 0;
      m_starve[0] = 0; m_starve[1] = 0;
      return;
    end
    for (int t = 0; t < 2; t++) begin
      v = m_occ[t] + ((cur_wa == 1 && cur_wt == t) ? cur_wk : 0)
                   - ((e_grant == 1 && e_thread == t) ? e_n : 0);
      if (cur_ex == 1 && cur_ext == t) v = 0;
      else if (v > 16) begin v = 16; m_err = 1; end
      else if (v < 0)  begin v = 0;  m_err = 1; end
      m_occ[t] = v;
      if (!m_el[t] || (e_grant == 1 && e_thread == t)) m_starve[t] = 0;
      else if (m_starve[t] < 7) m_starve[t]++;
    end
    if (e_grant == 1) m_last = e_thread;
  endtask

  // Drive one cycle's inputs, then compare every output with the model.
  task automatic applyStimulus(input int r, input int ex, input int ext, input int wa,
                               input int wt, input int wk, input int te, input int be);
    cur_rst = r; cur_ex = ex; cur_ext = ext; cur_wa = wa; cur_wt = wt; cur_wk = wk;
    rst               = r[0];
    bus.except        = ex[0];
    bus.except_thread = ext[0];
    bus.wr_acc        = wa[0];
    bus.wr_thread     = wt[0];
    bus.wr_cnt        = 5'(1 << wk);
    bus.thr_en        = te[1:0];
    bus.be_slots      = be[1:0];
    #1;
    modelDecide();
    checkOutput("stall",       int'(bus.stall),       1 - e_grant);
    checkOutput("read_thread", int'(bus.read_thread), e_thread);
    checkOutput("read_cnt",    int'(bus.read_cnt),    (e_grant == 1) ? (1 << e_n) : 1);
    checkOutput("occ0",        int'(bus.occ0),        m_occ[0]);
    checkOutput("occ1",        int'(bus.occ1),        m_occ[1]);
    checkOutput("err",         int'(bus.err),         m_err);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    clockEdge();
  endtask

  initial begin
    rst = 1'b1;
    bus.except = 1'b0; bus.except_thread = 1'b0; bus.wr_acc = 1'b0;
    bus.wr_thread = 1'b0; bus.wr_cnt = 5'b00001; bus.thr_en = 2'b00; bus.be_slots = 2'd0;
    m_occ[0] = 0; m_occ[1] = 0; m_last = 0; m_err = 0;
    m_starve[0] = 0; m_starve[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then write 4 to thread 0 with no backend capacity.
    applyStimulus(0, 0, 0, 1, 0, 4, 3, 0);
    checkOutput("rst_stall", int'(bus.stall), 1);
    checkOutput("rst_read_cnt", int'(bus.read_cnt), 1);
    checkOutput("rst_read_thread", int'(bus.read_thread), 0);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 2);
    checkOutput("fill_occ0", int'(bus.occ0), 4);
    checkOutput("two_read_thread", int'(bus.read_thread), 0);
    checkOutput("two_read_cnt", int'(bus.read_cnt), 4);
    clockEdge();

    // Tie break and larger-occupancy selection.
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 0);
    checkOutput("drain_occ0", int'(bus.occ0), 2);
    clockEdge();
    applyStimulus(0, 0, 0, 1, 1, 3, 0, 0);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 2);
    checkOutput("tie_occ1", int'(bus.occ1), 3);
    checkOutput("tie_thread", int'(bus.read_thread), 1);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 2);
    checkOutput("larger_thread", int'(bus.read_thread), 0);
    clockEdge();

    // Flush of thread 1 beats a simultaneous write.
    applyStimulus(0, 0, 0, 1, 1, 4, 0, 0);
    clockEdge();
    applyStimulus(0, 1, 1, 1, 1, 4, 3, 2);
    checkOutput("flush_pre_occ1", int'(bus.occ1), 5);
    checkOutput("flush_thread", int'(bus.read_thread), 0);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_occ1", int'(bus.occ1), 0);
    clockEdge();

    // Overflow clamps at 16 and err stays set.
    repeat (4) begin
      applyStimulus(0, 0, 0, 1, 0, 4, 0, 0);
      clockEdge();
    end
    applyStimulus(0, 0, 0, 1, 0, 2, 0, 0);
    checkOutput("ovf_pre_err", int'(bus.err), 0);
    clockEdge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("ovf_occ0", int'(bus.occ0), 16);
      checkOutput("ovf_err_sticky", int'(bus.err), 1);
      clockEdge();
    end

    // Thread 1 with a single entry against a persistently fuller thread 0.
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
    clockEdge();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 1, 3, 1);
      checkOutput("starve_thread", int'(bus.read_thread), (STARVE && i == 4) ? 1 : 0);
      clockEdge();
    end

    // Reset while a grant is in progress.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 2);
    checkOutput("rst_grant_active", int'(bus.stall), 0);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_mid_occ0", int'(bus.occ0), 0);
    checkOutput("rst_mid_occ1", int'(bus.occ1), 0);
    checkOutput("rst_mid_stall", int'(bus.stall), 1);
    checkOutput("rst_mid_err", int'(bus.err), 0);
    clockEdge();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0) ? 1 : 0,
                    ($urandom_range(0, 9) == 0) ? 1 : 0,
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
      clockEdge();
    end
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
